alu_serial_ctrl: RTL and testbench
==================================

# alu_serial_ctrl

Bit-serial sequencer that drives the team's 1-bit ALU slice and collects its output to produce a full WIDTH-bit result for AND, OR, ADD, SUB and SLT. It accepts a start request carrying operands and a 6-bit function code. It then feeds the slice one bit per cycle, LSB first, and registers the carry between bits. It resolves SLT from the sign and overflow of a serial subtraction. It sits between the datapath issue logic and a single slice instance, trading latency for area.

## Interface
- WIDTH, 32, operand/result width in bits (≥2)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- Signal  in  6  function code: AND=6'b100100, OR=6'b100101, ADD=6'b100000, SUB=6'b100010, SLT=6'b101010
- dataA  in  WIDTH  operand A, latched on accepted start
- dataB  in  WIDTH  operand B, latched on accepted start
- busy  out  1  high while bits are being processed
- done  out  1  one-cycle completion pulse
- err  out  1  unsupported Signal on last accepted start
- overflow  out  1  signed overflow of last ADD/SUB (see Configuration)
- dataOut  out  WIDTH  registered result
- slice_a  out  1  A bit to slice
- slice_b  out  1  B bit to slice
- slice_cin  out  1  carry-in to slice
- slice_invert  out  1  B-invert to slice
- slice_less  out  1  less input to slice; tied 0
- slice_signal  out  6  function code to slice
- slice_out  in  1  slice result bit
- slice_cout  in  1  slice carry-out

## Operation
- States: IDLE, RUN, DONE.
- IDLE + start=1 with a supported Signal:
  - latch dataA, dataB and Signal;
  - clear bit_cnt;
  - go to RUN.
- IDLE + start=1 with an unsupported Signal:
  - go directly to DONE with dataOut=0, err=1 and overflow=0.
- start in RUN or DONE is ignored and not queued.
- Slice drive in RUN is combinational from registers:
  - slice_a=A_reg[bit_cnt], slice_b=B_reg[bit_cnt];
  - slice_cin = carry register, initialised to 1 for SUB/SLT and 0 otherwise;
  - slice_invert = 1 for SUB/SLT;
  - slice_signal = SUB code when the op is SLT, else the latched Signal.
- Each RUN cycle:
  - result_sr[bit_cnt] <= slice_out;
  - carry <= slice_cout;
  - record the MSB carry-in when bit_cnt=WIDTH-1;
  - bit_cnt increments.
- Last RUN cycle (bit_cnt=WIDTH-1) loads dataOut, then goes to DONE:
  - AND/OR/ADD/SUB: dataOut = assembled result.
  - SLT: dataOut = {WIDTH-1 zeros, sum_msb XOR (cin_msb XOR cout_msb)}.
- DONE lasts one cycle, with done=1, then returns to IDLE.
- Outside RUN all slice_* outputs are 0.
- dataOut, err and overflow hold until the next accepted start. err is cleared on a supported start.
- Reset (asserted low) at any time:
  - forces IDLE;
  - all outputs and registers go to 0;
  - an in-flight operation is discarded with no done pulse.

## Timing
- Start accepted at edge E0. busy=1 from after E0 until after E_WIDTH.
- Bits are captured at E1..E_WIDTH.
- dataOut is valid and done=1 after E_WIDTH, i.e. WIDTH cycles after acceptance. done drops after E_WIDTH+1.
- Earliest next accept is E_WIDTH+2, giving throughput of one op per WIDTH+2 cycles.
- Unsupported op: done=1 in the cycle after E0, with latency 1.
- Reset values: busy=0, done=0, err=0, overflow=0, dataOut=0, all slice_*=0.
- Arithmetic is modulo 2^WIDTH; carry-out of the MSB is discarded except for overflow/SLT.

## Configuration
- ALU_SERIAL_OVF_EN defined:
  - on ADD/SUB completion, overflow = cin_msb XOR cout_msb;
  - overflow is 0 for AND/OR/SLT/unsupported.
- ALU_SERIAL_OVF_EN undefined:
  - overflow is tied to 0 and the MSB-carry capture used only for overflow is removed;
  - SLT still computes its own overflow correction internally;
  - the port list is identical.

## Test plan
- WIDTH=32, ADD 0x00000005+0x00000003 -> dataOut=0x00000008, done exactly 32 cycles after the start edge; SUB 3−5 -> 0xFFFFFFFE.
- AND 0xF0F0F0F0,0xFF00FF00 -> 0xF000F000; OR of the same -> 0xFFF0FFF0; slice_signal observed equal to Signal during RUN.
- SLT 0xFFFFFFFF vs 0x00000001 -> 1; SLT 0x7FFFFFFF vs 0x80000000 -> 0 (overflow-corrected); slice_signal=6'b100010 during RUN.
- Signal=6'b000000 -> done one cycle after accept, dataOut=0, err=1; a following valid ADD clears err.
- start held high during RUN -> ignored, single done. Reset asserted at bit 10 -> busy=0, dataOut=0, no done pulse; a new op afterwards completes correctly.
- With ALU_SERIAL_OVF_EN: ADD 0x7FFFFFFF+1 -> dataOut=0x80000000, overflow=1. Without the macro, the same stimulus gives overflow=0.

Source files
------------

// File: rtl/alu_serial_ctrl.sv
// ---------------------------------------------------------------------------
// alu_serial_ctrl
//
// Bit-serial sequencer for a single 1-bit ALU slice. On an accepted start it
// latches the operands and function code. It then presents one operand bit
// pair per cycle to the slice, LSB first, and registers the slice carry
// between bits. It assembles the WIDTH-bit result from the slice outputs.
// Supported operations are AND, OR, ADD, SUB and SLT. SLT runs as a serial
// subtraction and resolves "less than" from the MSB sum and its overflow.
//
// Optional feature: define ALU_SERIAL_OVF_EN to report signed overflow of
// ADD/SUB on the overflow port. When it is undefined, overflow stays 0 and the
// port list does not change.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   start         operation request, sampled only while idle
//   Signal[5:0]   function code (AND/OR/ADD/SUB/SLT)
//   dataA, dataB  operands, latched on an accepted start
//   busy          high while bits are being processed
//   done          one-cycle completion pulse
//   err           last accepted start carried an unsupported code
//   overflow      signed overflow of the last ADD/SUB (optional feature)
//   dataOut       registered result
//   slice_*       drive to / result from the external 1-bit ALU slice
// ---------------------------------------------------------------------------
module alu_serial_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       Signal,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             overflow,
    output logic [WIDTH-1:0] dataOut,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic             slice_invert,
    output logic             slice_less,
    output logic [5:0]       slice_signal,
    input  logic             slice_out,
    input  logic             slice_cout
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_SLT = 6'b101010;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] result_q;
    logic [5:0]       op_q;
    logic [CW-1:0]    bit_cnt_q;
    logic             carry_q;

    logic start_supported;
    logic start_is_sub;
    logic op_is_sub;
    logic last_bit;
    logic msb_ovf;
    logic slt_bit;
    logic ovf_last;

    assign start_supported = Signal inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT};
    assign start_is_sub    = (Signal == OP_SUB) || (Signal == OP_SLT);
    assign op_is_sub       = (op_q == OP_SUB) || (op_q == OP_SLT);
    assign last_bit        = (bit_cnt_q == CW'(WIDTH - 1));

    // On the MSB cycle carry_q is the MSB carry-in and slice_cout the MSB
    // carry-out. Their XOR is the signed overflow of the addition in flight,
    // so no separate capture register is needed.
    assign msb_ovf = carry_q ^ slice_cout;

    // For a < b (signed), the sign of a - b is wrong exactly when the
    // subtraction overflowed.
    assign slt_bit = slice_out ^ msb_ovf;

`ifdef ALU_SERIAL_OVF_EN
    assign ovf_last = ((op_q == OP_ADD) || (op_q == OP_SUB)) && msb_ovf;
`else
    assign ovf_last = 1'b0;
`endif

    assign slice_less = 1'b0;

    // Slice drive is combinational from the operand registers. It is held at
    // zero outside RUN so the slice sees a quiet bus.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value
        // unassigned, which would otherwise infer a latch.
        slice_a      = 1'b0;
        slice_b      = 1'b0;
        slice_cin    = 1'b0;
        slice_invert = 1'b0;
        slice_signal = 6'b000000;
        if (state_q == S_RUN) begin
            slice_a      = a_q[bit_cnt_q];
            slice_b      = b_q[bit_cnt_q];
            slice_cin    = carry_q;
            slice_invert = op_is_sub;
            slice_signal = (op_q == OP_SLT) ? OP_SUB : op_q;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement
    // order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            op_q      <= '0;
            bit_cnt_q <= '0;
            carry_q   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            overflow  <= 1'b0;
            dataOut   <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (start_supported) begin
                            a_q       <= dataA;
                            b_q       <= dataB;
                            op_q      <= Signal;
                            bit_cnt_q <= '0;
                            result_q  <= '0;
                            // A subtraction is A + ~B + 1, so the carry
                            // starts at 1.
                            carry_q   <= start_is_sub;
                            err       <= 1'b0;
                            busy      <= 1'b1;
                            state_q   <= S_RUN;
                        end else begin
                            // Unsupported codes skip the slice entirely.
                            dataOut  <= '0;
                            err      <= 1'b1;
                            overflow <= 1'b0;
                            done     <= 1'b1;
                            state_q  <= S_DONE;
                        end
                    end
                end

                S_RUN: begin
                    result_q[bit_cnt_q] <= slice_out;
                    carry_q             <= slice_cout;
                    bit_cnt_q           <= bit_cnt_q + CW'(1);
                    if (last_bit) begin
                        // The MSB lands in result_q on this same edge, so
                        // the final word is assembled from slice_out directly.
                        if (op_q == OP_SLT) begin
                            dataOut <= {{(WIDTH-1){1'b0}}, slt_bit};
                        end else begin
                            dataOut <= {slice_out, result_q[WIDTH-2:0]};
                        end
                        overflow <= ovf_last;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_serial_ctrl
//
// Self-checking bench for alu_serial_ctrl (WIDTH=32). It provides a
// behavioural 1-bit ALU slice. A transaction-level reference tracks when
// each operation is accepted, how long it stays busy and what it must
// produce. One compare process checks the DUT against that reference on
// every falling edge. Directed operations also pin results to literal
// values.
// ---------------------------------------------------------------------------
module tb_alu_serial_ctrl;

    localparam int WIDTH = 32;

    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_SLT = 6'b101010;

`ifdef ALU_SERIAL_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic             clk    = 1'b0;
    logic             reset  = 1'b0;
    logic             start  = 1'b0;
    logic [5:0]       Signal = 6'b0;
    logic [WIDTH-1:0] dataA  = '0;
    logic [WIDTH-1:0] dataB  = '0;
    logic             busy;
    logic             done;
    logic             err;
    logic             overflow;
    logic [WIDTH-1:0] dataOut;
    logic             slice_a;
    logic             slice_b;
    logic             slice_cin;
    logic             slice_invert;
    logic             slice_less;
    logic [5:0]       slice_signal;
    logic             slice_out;
    logic             slice_cout;

    int n_checks = 0;
    int n_errors = 0;

    alu_serial_ctrl #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .Signal       (Signal),
        .dataA        (dataA),
        .dataB        (dataB),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .overflow     (overflow),
        .dataOut      (dataOut),
        .slice_a      (slice_a),
        .slice_b      (slice_b),
        .slice_cin    (slice_cin),
        .slice_invert (slice_invert),
        .slice_less   (slice_less),
        .slice_signal (slice_signal),
        .slice_out    (slice_out),
        .slice_cout   (slice_cout)
    );

    always #5 clk = ~clk;

    // Behavioural 1-bit ALU slice.
    logic s_bb;
    always_comb begin
        s_bb       = slice_b ^ slice_invert;
        slice_cout = (slice_a & s_bb) | (slice_a & slice_cin) | (s_bb & slice_cin);
        case (slice_signal)
            OP_AND:         slice_out = slice_a & s_bb;
            OP_OR:          slice_out = slice_a | s_bb;
            OP_ADD, OP_SUB: slice_out = slice_a ^ s_bb ^ slice_cin;
            default:        slice_out = slice_less;
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference: arithmetic view of each operation -----------
    function automatic logic supported(input logic [5:0] s);
        return s inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT};
    endfunction

    function automatic logic [WIDTH-1:0] ref_result(input logic [5:0] s,
                                                    input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
        case (s)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SLT:  return ($signed(a) < $signed(b)) ? WIDTH'(1) : WIDTH'(0);
            default: return '0;
        endcase
    endfunction

    function automatic logic ref_ovf(input logic [5:0] s,
                                     input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        logic             v;
        v = 1'b0;
        if (s == OP_ADD) begin
            r = a + b;
            v = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
        end else if (s == OP_SUB) begin
            r = a - b;
            v = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
        end
        return OVF_EN && v;
    endfunction

    // Carry into bit i of a + (inv ? ~b : b) + inv, from a wide sum of the
    // lower i bits.
    function automatic logic ref_carry(input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] b,
                                       input logic inv, input int i);
        logic [63:0] mask;
        logic [63:0] s;
        mask = (64'd1 << i) - 64'd1;
        s = (64'(a) & mask) + (64'(inv ? ~b : b) & mask) + 64'(inv);
        return s[i];
    endfunction

    // ---------------- reference: transaction timeline ------------------------
    int               m_left = 0;      // bit cycles still to run
    logic             m_done = 1'b0;
    logic             m_err  = 1'b0;
    logic             m_ovf  = 1'b0;
    logic [WIDTH-1:0] m_data = '0;
    logic [WIDTH-1:0] m_a    = '0;
    logic [WIDTH-1:0] m_b    = '0;
    logic [5:0]       m_sig  = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_err  <= 1'b0;
            m_ovf  <= 1'b0;
            m_data <= '0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done <= 1'b1;
                m_data <= ref_result(m_sig, m_a, m_b);
                m_ovf  <= ref_ovf(m_sig, m_a, m_b);
            end
        end else if (start) begin
            if (supported(Signal)) begin
                m_left <= WIDTH;
                m_a    <= dataA;
                m_b    <= dataB;
                m_sig  <= Signal;
                m_err  <= 1'b0;
            end else begin
                m_done <= 1'b1;
                m_data <= '0;
                m_err  <= 1'b1;
                m_ovf  <= 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare --------------------------------------
    always @(negedge clk) begin
        int   idx;
        logic inv;
        check("busy", busy, 64'(m_left > 0));
        check("done", done, 64'(m_done));
        check("err", err, 64'(m_err));
        check("slice_less", slice_less, 64'd0);
        if (m_left > 0) begin
            idx = WIDTH - m_left;
            inv = (m_sig == OP_SUB) || (m_sig == OP_SLT);
            check("slice_a", slice_a, 64'(m_a[idx]));
            check("slice_b", slice_b, 64'(m_b[idx]));
            check("slice_invert", slice_invert, 64'(inv));
            check("slice_cin", slice_cin, 64'(ref_carry(m_a, m_b, inv, idx)));
            check("slice_signal", slice_signal, 64'((m_sig == OP_SLT) ? OP_SUB : m_sig));
        end else begin
            check("dataOut", dataOut, 64'(m_data));
            check("overflow", overflow, 64'(m_ovf));
            check("slice_idle", {slice_a, slice_b, slice_cin, slice_invert, slice_signal}, 64'd0);
        end
    end

    // ---------------- stimulus -----------------------------------------------
    // Issues one start and waits for done. Latency is the number of edges after
    // the accepting edge: WIDTH for supported ops, 0 for unsupported ones.
    task automatic run_op(input string name, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [5:0] sig,
                          input bit hold, input bit chk, input logic [WIDTH-1:0] exp);
        int n;
        @(posedge clk); #2;
        start  = 1'b1;
        dataA  = a;
        dataB  = b;
        Signal = sig;
        @(posedge clk); #2;
        if (!hold) start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        start = 1'b0;
        check({name, "_latency"}, 64'(n), 64'(supported(sig) ? WIDTH : 0));
        if (chk) check({name, "_result"}, dataOut, 64'(exp));
    endtask

    initial begin
        logic [5:0]       rs;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;

        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("rst_busy", busy, 64'd0);
        check("rst_done", done, 64'd0);
        check("rst_err", err, 64'd0);
        check("rst_ovf", overflow, 64'd0);
        check("rst_dataOut", dataOut, 64'd0);
        check("rst_slice", {slice_a, slice_b, slice_cin, slice_invert, slice_less, slice_signal}, 64'd0);
        @(posedge clk); #2;
        reset = 1'b1;

        run_op("add", 32'h00000005, 32'h00000003, OP_ADD, 1'b0, 1'b1, 32'h00000008);
        run_op("sub", 32'h00000003, 32'h00000005, OP_SUB, 1'b0, 1'b1, 32'hFFFFFFFE);
        run_op("and", 32'hF0F0F0F0, 32'hFF00FF00, OP_AND, 1'b0, 1'b1, 32'hF000F000);
        run_op("or",  32'hF0F0F0F0, 32'hFF00FF00, OP_OR,  1'b0, 1'b1, 32'hFFF0FFF0);
        run_op("slt_neg", 32'hFFFFFFFF, 32'h00000001, OP_SLT, 1'b0, 1'b1, 32'h00000001);
        run_op("slt_ovf", 32'h7FFFFFFF, 32'h80000000, OP_SLT, 1'b0, 1'b1, 32'h00000000);
        run_op("bad", 32'h12345678, 32'h9ABCDEF0, 6'b000000, 1'b0, 1'b1, 32'h00000000);
        check("bad_err", err, 64'd1);
        run_op("add_clr", 32'h00000010, 32'h00000020, OP_ADD, 1'b0, 1'b1, 32'h00000030);
        check("add_clr_err", err, 64'd0);
        run_op("ovf_add", 32'h7FFFFFFF, 32'h00000001, OP_ADD, 1'b0, 1'b1, 32'h80000000);
        check("ovf_flag", overflow, 64'(OVF_EN));
        run_op("hold", 32'h00000100, 32'h00000001, OP_SUB, 1'b1, 1'b1, 32'h000000FF);
        repeat (4) @(posedge clk);

        // Reset in the middle of an operation: discarded, no done pulse.
        @(posedge clk); #2;
        start = 1'b1; Signal = OP_ADD; dataA = 32'h00001111; dataB = 32'h00002222;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_busy", busy, 64'd0);
        check("midrst_dataOut", dataOut, 64'd0);
        check("midrst_done", done, 64'd0);
        @(posedge clk); #2;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        run_op("after_rst", 32'h0000000A, 32'h00000007, OP_ADD, 1'b0, 1'b1, 32'h00000011);

        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 6))
                0:       rs = OP_AND;
                1:       rs = OP_OR;
                2:       rs = OP_ADD;
                3:       rs = OP_SUB;
                4:       rs = OP_SLT;
                5: begin
                    rs = 6'($urandom);
                    if (supported(rs)) rs = 6'b111111;
                end
                default: rs = OP_ADD;
            endcase
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) ra = ($urandom_range(0, 1) == 0) ? 32'h80000000 : 32'h7FFFFFFF;
            if ($urandom_range(0, 3) == 0) rb = ($urandom_range(0, 1) == 0) ? 32'hFFFFFFFF : 32'h80000000;
            run_op("rand", ra, rb, rs, 1'($urandom_range(0, 1)), 1'b0, '0);
        end
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
